// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: BIST sequencer that drives c17 from a 5-bit LFSR and compacts its responses into a MISR;
// latency: first pattern 2 cycles after the start edge, done NUM_PATTERNS+2 cycles after it.
// Backpressure: none; start is honoured only in IDLE/DONE. Optional build macro C17_BIST_SELFCHECK_EN.
module c17_bist_ctrl #(
    parameter int unsigned      NUM_PATTERNS = 31,
    parameter logic [4:0]       LFSR_SEED    = 5'h01,
    parameter int unsigned      SIG_W        = 16,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [4:0]       cut_in,
    input  logic [1:0]       cut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [4:0]       pat_cnt
`ifdef C17_BIST_SELFCHECK_EN
    ,
    output logic             fail_seen,
    output logic [4:0]       fail_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Feedback taps (x^SIG_W term implied). 16 uses the CCITT polynomial; unlisted widths fall back to x+1.
    function automatic logic [31:0] poly_lookup(input int unsigned w);
        case (w)
            2, 3, 4, 6, 7, 15: poly_lookup = 32'h0000_0003;
            5, 11:             poly_lookup = 32'h0000_0005;
            8:                 poly_lookup = 32'h0000_001D;
            9:                 poly_lookup = 32'h0000_0011;
            10:                poly_lookup = 32'h0000_0009;
            12:                poly_lookup = 32'h0000_0053;
            13:                poly_lookup = 32'h0000_001B;
            14:                poly_lookup = 32'h0000_002B;
            16:                poly_lookup = 32'h0000_1021;
            24:                poly_lookup = 32'h0000_0087;
            32:                poly_lookup = 32'h04C1_1DB7;
            default:           poly_lookup = 32'h0000_0003;
        endcase
    endfunction

    localparam logic [SIG_W-1:0] POLY        = SIG_W'(poly_lookup(SIG_W));
    localparam logic [4:0]       LAST_CNT    = 5'(NUM_PATTERNS);
    localparam bit               NO_PATTERNS = (NUM_PATTERNS == 0);

    state_t           state, state_nxt;
    logic [4:0]       lfsr, lfsr_nxt;      // doubles as the registered cut_in; zero outside RUN
    logic [SIG_W-1:0] misr, misr_nxt, misr_step;
    logic [4:0]       cnt, cnt_nxt;
    logic             pass_q, pass_nxt;
    logic             entering_done;

`ifdef C17_BIST_SELFCHECK_EN
    // Reference c17: 10=NAND(1,3) 11=NAND(3,6) 16=NAND(2,11) 19=NAND(11,7) 22=NAND(10,16) 23=NAND(16,19)
    function automatic logic [1:0] c17_ref(input logic [4:0] v);
        logic n10, n11, n16, n19;
        n10 = ~(v[0] & v[2]);
        n11 = ~(v[2] & v[3]);
        n16 = ~(v[1] & n11);
        n19 = ~(n11 & v[4]);
        c17_ref = {~(n16 & n19), ~(n10 & n16)};
    endfunction

    logic       fs_q, fs_nxt;
    logic [4:0] fi_q, fi_nxt;
`endif

    // MISR absorb of the response c17 presents for the current pattern
    always_comb begin
        misr_step = {misr[SIG_W-2:0], 1'b0} ^ (misr[SIG_W-1] ? POLY : '0) ^ SIG_W'(cut_out);
    end

    // Next-state and datapath updates; pass is captured on the edge that enters DONE
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        misr_nxt  = misr;
        cnt_nxt   = cnt;
        pass_nxt  = pass_q;
`ifdef C17_BIST_SELFCHECK_EN
        fs_nxt    = fs_q;
        fi_nxt    = fi_q;
`endif
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                misr_nxt = '0;
                cnt_nxt  = '0;
                pass_nxt = 1'b0;
`ifdef C17_BIST_SELFCHECK_EN
                fs_nxt   = 1'b0;
                fi_nxt   = '0;
`endif
                if (NO_PATTERNS) begin
                    state_nxt = DONE;
                    lfsr_nxt  = '0;
                end else begin
                    state_nxt = RUN;
                    lfsr_nxt  = LFSR_SEED;
                end
            end
            RUN: begin
                misr_nxt = misr_step;
                cnt_nxt  = cnt + 5'd1;
                lfsr_nxt = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
`ifdef C17_BIST_SELFCHECK_EN
                if (!fs_q && (c17_ref(lfsr) != cut_out)) begin
                    fs_nxt = 1'b1;
                    fi_nxt = cnt;
                end
`endif
                if (cnt_nxt == LAST_CNT) begin
                    state_nxt = DONE;
                    lfsr_nxt  = '0;
                end
            end
            DONE: begin
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase

        entering_done = (state != DONE) && (state_nxt == DONE);
        if (entering_done) begin
`ifdef C17_BIST_SELFCHECK_EN
            pass_nxt = (misr_nxt == GOLDEN_SIG) && !fs_nxt;
`else
            pass_nxt = (misr_nxt == GOLDEN_SIG);
`endif
        end
    end

    // State and datapath registers; reset wins in every state, so a mid-run reset leaves no partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lfsr   <= '0;
            misr   <= '0;
            cnt    <= '0;
            pass_q <= 1'b0;
`ifdef C17_BIST_SELFCHECK_EN
            fs_q   <= 1'b0;
            fi_q   <= '0;
`endif
        end else begin
            state  <= state_nxt;
            lfsr   <= lfsr_nxt;
            misr   <= misr_nxt;
            cnt    <= cnt_nxt;
            pass_q <= pass_nxt;
`ifdef C17_BIST_SELFCHECK_EN
            fs_q   <= fs_nxt;
            fi_q   <= fi_nxt;
`endif
        end
    end

    assign cut_in    = lfsr;
    assign busy      = (state == LOAD) || (state == RUN);
    assign done      = (state == DONE);
    assign pass      = pass_q;
    assign signature = misr;
    assign pat_cnt   = cnt;
`ifdef C17_BIST_SELFCHECK_EN
    assign fail_seen = fs_q;
    assign fail_idx  = fi_q;
`endif

endmodule
